// File: rtl/e10_csr_mailbox.sv
// ---------------------------------------------------------------------------
// e10_csr_mailbox
//
// Indirect CSR mailbox between the AFU MMIO decoder and the four per-port
// E10 MAC CSR slaves. Software stages a 32-bit WDATA word and then writes CMD.
// That write launches exactly one Avalon-MM read or write on the MAC CSR bus.
// Software then polls STATUS and collects read results from RDATA.
//
// MMIO register map (index on mmio_*_idx):
//   0 CMD    [15:0] address, [16] write, [17] read, [19:18] port.
//            A read returns the last accepted command.
//   1 WDATA  [31:0] write data. Writable at any time.
//   2 RDATA  [31:0] read result. Read-only.
//   3 STATUS [0] busy, [1] done, [2] timeout, [3] cmd_err.
//            cmd_err is sticky and is cleared by writing 1 to bit 3.
//
// Ports:
//   pClk, pck_cp2af_softReset_n      clock and async active-low reset
//   mmio_wr_valid/idx/data           one-cycle MMIO write
//   mmio_rd_valid/idx/tid            one-cycle MMIO read request
//   mmio_rsp_valid/tid/data          read response, one cycle after request
//   port_sel                         target MAC, stable between accepts
//   avmm_address/read/write/...      Avalon-MM master towards the MAC CSRs
// ---------------------------------------------------------------------------
module e10_csr_mailbox #(
    parameter int          TIMEOUT_CYCLES  = 1024,
    parameter logic [31:0] RD_TIMEOUT_DATA = 32'hDEAD_BEEF
) (
    input  logic        pClk,
    input  logic        pck_cp2af_softReset_n,
    input  logic        mmio_wr_valid,
    input  logic [1:0]  mmio_wr_idx,
    input  logic [63:0] mmio_wr_data,
    input  logic        mmio_rd_valid,
    input  logic [1:0]  mmio_rd_idx,
    input  logic [8:0]  mmio_rd_tid,
    output logic        mmio_rsp_valid,
    output logic [8:0]  mmio_rsp_tid,
    output logic [63:0] mmio_rsp_data,
    output logic [1:0]  port_sel,
    output logic [15:0] avmm_address,
    output logic        avmm_read,
    output logic        avmm_write,
    output logic [31:0] avmm_writedata,
    input  logic [31:0] avmm_readdata,
    input  logic        avmm_readdatavalid,
    input  logic        avmm_waitrequest
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WRITE   = 2'd1,
        ST_READ    = 2'd2,
        ST_RD_WAIT = 2'd3
    } state_t;

    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [19:0]       cmd_r;
    logic [31:0]       wdata_r;
    logic [31:0]       rdata_r;
    logic              done_r;
    logic              timeout_r;
    logic              cmd_err_r;

    logic              busy_s;
    logic              cmd_wr_s;
    logic              cmd_wbit_s;
    logic              cmd_rbit_s;
    logic              accept_s;
    logic              cmd_bad_s;
    logic              cnt_last_s;
    logic [3:0]        status_s;
    logic [31:0]       rd_mux_s;
    logic              unused_ok_s;

    // Only the low 32 bits of any MMIO write carry register content.
    assign unused_ok_s = ^mmio_wr_data[63:32];

    assign busy_s     = (state_r != ST_IDLE);
    assign cmd_wr_s   = mmio_wr_valid && (mmio_wr_idx == 2'd0);
    assign cmd_wbit_s = mmio_wr_data[16];
    assign cmd_rbit_s = mmio_wr_data[17];
    assign cnt_last_s = (cnt_r == CNT_LAST);

    // A command with neither operation bit is a silent clear-write. A command
    // with both bits is malformed. A command arriving while busy is dropped.
    // This includes the edge on which the current transaction completes.
    assign accept_s  = cmd_wr_s && (cmd_wbit_s ^ cmd_rbit_s) && !busy_s;
    assign cmd_bad_s = cmd_wr_s && ((cmd_wbit_s && cmd_rbit_s) ||
                                    ((cmd_wbit_s || cmd_rbit_s) && busy_s));

    // STATUS as seen by a read on this edge. A read coinciding with an accept
    // already reports the new transaction as busy.
    always_comb begin
        status_s = 4'h0;
        if (accept_s) begin
            status_s = {cmd_err_r, 1'b0, 1'b0, 1'b1};
        end else begin
            status_s = {cmd_err_r, timeout_r, done_r, busy_s};
        end
    end

    // MMIO read data select. Uses pre-edge register values.
    always_comb begin
        rd_mux_s = 32'h0000_0000;
        case (mmio_rd_idx)
            2'd0:    rd_mux_s = {12'h000, cmd_r};
            2'd1:    rd_mux_s = wdata_r;
            2'd2:    rd_mux_s = rdata_r;
            2'd3:    rd_mux_s = {28'h000_0000, status_s};
            default: rd_mux_s = 32'h0000_0000;
        endcase
    end

    // MMIO read response: always answered, exactly one cycle later.
    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            mmio_rsp_valid <= 1'b0;
            mmio_rsp_tid   <= 9'd0;
            mmio_rsp_data  <= 64'h0;
        end else begin
            mmio_rsp_valid <= mmio_rd_valid;
            if (mmio_rd_valid) begin
                mmio_rsp_tid  <= mmio_rd_tid;
                mmio_rsp_data <= {32'h0000_0000, rd_mux_s};
            end
        end
    end

    // Software-visible registers: CMD shadow, WDATA and sticky cmd_err.
    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            cmd_r     <= 20'h0_0000;
            wdata_r   <= 32'h0000_0000;
            cmd_err_r <= 1'b0;
        end else begin
            if (accept_s) begin
                cmd_r <= mmio_wr_data[19:0];
            end
            if (mmio_wr_valid && (mmio_wr_idx == 2'd1)) begin
                wdata_r <= mmio_wr_data[31:0];
            end
            if (cmd_bad_s) begin
                cmd_err_r <= 1'b1;
            end else if (mmio_wr_valid && (mmio_wr_idx == 2'd3) && mmio_wr_data[3]) begin
                cmd_err_r <= 1'b0;
            end
        end
    end

    // Transaction FSM with Avalon strobes, timeout counter, done/timeout and RDATA.
    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            state_r        <= ST_IDLE;
            cnt_r          <= '0;
            avmm_read      <= 1'b0;
            avmm_write     <= 1'b0;
            avmm_address   <= 16'h0000;
            avmm_writedata <= 32'h0000_0000;
            port_sel       <= 2'd0;
            rdata_r        <= 32'h0000_0000;
            done_r         <= 1'b0;
            timeout_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // Late readdatavalid pulses land here and are ignored.
                    if (accept_s) begin
                        state_r        <= cmd_wbit_s ? ST_WRITE : ST_READ;
                        avmm_write     <= cmd_wbit_s;
                        avmm_read      <= cmd_rbit_s;
                        avmm_address   <= mmio_wr_data[15:0];
                        port_sel       <= mmio_wr_data[19:18];
                        avmm_writedata <= wdata_r;
                        cnt_r          <= '0;
                        done_r         <= 1'b0;
                        timeout_r      <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    // A slave handshake on the last allowed edge still counts as success.
                    if (!avmm_waitrequest) begin
                        avmm_write <= 1'b0;
                        state_r    <= ST_IDLE;
                        done_r     <= 1'b1;
                    end else if (cnt_last_s) begin
                        avmm_write <= 1'b0;
                        state_r    <= ST_IDLE;
                        done_r     <= 1'b1;
                        timeout_r  <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_READ: begin
                    if (!avmm_waitrequest && avmm_readdatavalid) begin
                        avmm_read <= 1'b0;
                        rdata_r   <= avmm_readdata;
                        state_r   <= ST_IDLE;
                        done_r    <= 1'b1;
                    end else if (cnt_last_s) begin
                        avmm_read <= 1'b0;
                        rdata_r   <= RD_TIMEOUT_DATA;
                        state_r   <= ST_IDLE;
                        done_r    <= 1'b1;
                        timeout_r <= 1'b1;
                    end else if (!avmm_waitrequest) begin
                        avmm_read <= 1'b0;
                        state_r   <= ST_RD_WAIT;
                        cnt_r     <= cnt_r + CNT_ONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_RD_WAIT: begin
                    if (avmm_readdatavalid) begin
                        rdata_r <= avmm_readdata;
                        state_r <= ST_IDLE;
                        done_r  <= 1'b1;
                    end else if (cnt_last_s) begin
                        rdata_r   <= RD_TIMEOUT_DATA;
                        state_r   <= ST_IDLE;
                        done_r    <= 1'b1;
                        timeout_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    avmm_read  <= 1'b0;
                    avmm_write <= 1'b0;
                end
            endcase
        end
    end

endmodule
